// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad and debounces both press and release.
// A one-cycle key_valid strobe marks each accepted press. key_code holds the last accepted key.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to get repeat strobes while a key is held.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 8,
    parameter int unsigned REPEAT_CNT   = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam int unsigned MW = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [1:0] S_SCAN     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_PRESSED  = 2'd2;

    // Reject parameter values the scan timing cannot support
    if ((SCAN_DIV < 4) || (DEBOUNCE_CNT < 1) || (REPEAT_CNT < 1)) begin : g_bad_params
        $error("keypad_scanner: illegal parameter value");
    end

    logic [1:0]    r_state, w_state_nxt;
    logic [SW-1:0] r_slot;
    logic [3:0]    r_row_s1, r_row_s2;
    logic [1:0]    r_col_idx, w_col_idx_nxt;
    logic [3:0]    r_col;
    logic [3:0]    r_cand, w_cand_nxt;
    logic [MW-1:0] r_match, w_match_nxt;
    logic [MW-1:0] r_release, w_release_nxt;
    logic [3:0]    r_key_code, w_key_code_nxt;
    logic          r_key_valid, w_key_valid_nxt;
    logic          r_key_held, w_key_held_nxt;
    logic          w_sample;
    logic          w_row_any;
    logic [1:0]    w_row_sel;
    logic          w_cand_row_high;
    logic          w_accept;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CNT + 1);
    logic [RW-1:0] r_repeat, w_repeat_nxt;
`endif

    assign w_sample        = (r_slot == SW'(SCAN_DIV - 1));
    assign w_row_any       = (r_row_s2 != 4'hF);
    assign w_cand_row_high = r_row_s2[r_cand[3:2]];

    // Lowest-index low row wins when several rows are low
    always_comb begin
        w_row_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_row_s2[i]) w_row_sel = 2'(i);
        end
    end

    // Next-state and datapath decisions, evaluated only at sample points
    always_comb begin
        w_state_nxt     = r_state;
        w_col_idx_nxt   = r_col_idx;
        w_cand_nxt      = r_cand;
        w_match_nxt     = r_match;
        w_release_nxt   = r_release;
        w_key_code_nxt  = r_key_code;
        w_key_valid_nxt = 1'b0;
        w_key_held_nxt  = r_key_held;
        w_accept        = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        w_repeat_nxt    = r_repeat;
`endif
        case (r_state)
            S_SCAN: begin
                if (w_sample) begin
                    if (w_row_any) begin
                        w_cand_nxt  = {w_row_sel, r_col_idx};
                        w_match_nxt = MW'(1);
                        if (DEBOUNCE_CNT == 1) w_accept    = 1'b1;
                        else                   w_state_nxt = S_DEBOUNCE;
                    end else begin
                        w_col_idx_nxt = r_col_idx + 2'd1;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (w_sample) begin
                    if (w_row_any && (w_row_sel == r_cand[3:2])) begin
                        if (r_match < MW'(DEBOUNCE_CNT)) w_match_nxt = r_match + MW'(1);
                        if (w_match_nxt == MW'(DEBOUNCE_CNT)) w_accept = 1'b1;
                    end else begin
                        w_state_nxt   = S_SCAN;
                        w_col_idx_nxt = r_col_idx + 2'd1;
                    end
                end
            end
            S_PRESSED: begin
                if (w_sample) begin
                    if (w_cand_row_high) begin
                        if (r_release < MW'(DEBOUNCE_CNT)) w_release_nxt = r_release + MW'(1);
                        if (w_release_nxt == MW'(DEBOUNCE_CNT)) begin
                            w_state_nxt    = S_SCAN;
                            w_col_idx_nxt  = 2'd0;
                            w_key_held_nxt = 1'b0;
                        end
                    end else begin
                        w_release_nxt = '0;
                    end
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                if (w_release_nxt != '0) begin
                    w_repeat_nxt = '0;
                end else if (w_sample) begin
                    w_repeat_nxt = r_repeat + RW'(1);
                    if (w_repeat_nxt == RW'(REPEAT_CNT)) begin
                        w_key_valid_nxt = 1'b1;
                        w_repeat_nxt    = '0;
                    end
                end
`endif
            end
            default: w_state_nxt = S_SCAN;
        endcase
        if (w_accept) begin
            w_state_nxt     = S_PRESSED;
            w_key_code_nxt  = w_cand_nxt;
            w_key_valid_nxt = 1'b1;
            w_key_held_nxt  = 1'b1;
            w_release_nxt   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            w_repeat_nxt    = '0;
`endif
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_SCAN;
        else     r_state <= w_state_nxt;
    end

    // Synchronizer, free-running slot counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_s1    <= 4'hF;
            r_row_s2    <= 4'hF;
            r_slot      <= '0;
            r_col_idx   <= 2'd0;
            r_col       <= 4'b1110;
            r_cand      <= 4'h0;
            r_match     <= '0;
            r_release   <= '0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_repeat    <= '0;
`endif
        end else begin
            r_row_s1    <= row;
            r_row_s2    <= r_row_s1;
            r_slot      <= w_sample ? '0 : r_slot + SW'(1);
            r_col_idx   <= w_col_idx_nxt;
            r_col       <= ~(4'b0001 << w_col_idx_nxt);
            r_cand      <= w_cand_nxt;
            r_match     <= w_match_nxt;
            r_release   <= w_release_nxt;
            r_key_code  <= w_key_code_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_held  <= w_key_held_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_repeat    <= w_repeat_nxt;
`endif
        end
    end

    assign col       = r_col;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and random keypad stimulus checked against a sample-level keypad model.
module tb_keypad_scanner;

    localparam int unsigned SD = 4;
    localparam int unsigned DB = 3;
    localparam int unsigned RP = 5;

    localparam int SCANNING = 0;
    localparam int CONFIRM  = 1;
    localparam int HOLDING  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = '0;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int m_strobes = 0;
    int cyc = 0;
    int strobe_cyc[$];

    // Model of the scanner as seen one sample at a time
    int         m_slot, m_c, m_mode, m_cr, m_cc, m_hits, m_rel, m_rep, m_code;
    logic       m_valid, m_held;
    logic [3:0] m_s1, m_s2;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .REPEAT_CNT(RP)) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_slot = 0; m_c = 0; m_mode = SCANNING; m_cr = 0; m_cc = 0;
        m_hits = 0; m_rel = 0; m_rep = 0; m_code = 0;
        m_valid = 1'b0; m_held = 1'b0; m_s1 = 4'hF; m_s2 = 4'hF;
    endtask

    task automatic accept();
        m_code  = m_cr * 4 + m_cc;
        m_valid = 1'b1;
        m_held  = 1'b1;
        m_mode  = HOLDING;
        m_rel   = 0;
        m_rep   = 0;
    endtask

    task automatic model_sample(input logic [3:0] rs);
        bit any;
        int sel;
        any = (rs != 4'hF);
        sel = 0;
        for (int i = 3; i >= 0; i--) if (!rs[i]) sel = i;
        case (m_mode)
            SCANNING: begin
                if (any) begin
                    m_cr = sel; m_cc = m_c; m_hits = 1;
                    if (m_hits >= int'(DB)) accept();
                    else m_mode = CONFIRM;
                end else begin
                    m_c = (m_c + 1) % 4;
                end
            end
            CONFIRM: begin
                if (any && sel == m_cr) begin
                    m_hits++;
                    if (m_hits >= int'(DB)) accept();
                end else begin
                    m_mode = SCANNING;
                    m_c = (m_c + 1) % 4;
                end
            end
            default: begin
                if (rs[m_cr]) m_rel++;
                else m_rel = 0;
                if (m_rel >= int'(DB)) begin
                    m_mode = SCANNING; m_c = 0; m_held = 1'b0;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                if (m_rel != 0) m_rep = 0;
                else begin
                    m_rep++;
                    if (m_rep == int'(RP)) begin m_valid = 1'b1; m_rep = 0; end
                end
`endif
            end
        endcase
    endtask

    // One clock: advance the model at the edge, compare all outputs mid-cycle
    task automatic tick();
        logic [3:0] rs;
        logic [3:0] e_col;
        @(posedge clk);
        rs = m_s2; m_s2 = m_s1; m_s1 = row;
        m_valid = 1'b0;
        if (m_slot == int'(SD) - 1) begin
            model_sample(rs);
            m_slot = 0;
        end else begin
            m_slot++;
        end
        cyc++;
        @(negedge clk);
        e_col = 4'hF ^ (4'h1 << m_c);
        chk("col", 8'(col), 8'(e_col));
        chk("key_code", 8'(key_code), 8'(m_code));
        chk("key_valid", 8'(key_valid), 8'(m_valid));
        chk("key_held", 8'(key_held), 8'(m_held));
        if (key_valid) begin strobes++; strobe_cyc.push_back(cyc); end
        if (m_valid) m_strobes++;
    endtask

    task automatic wait_strobe(input string tag, input int budget);
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        while (!seen && n < budget) begin
            tick(); n++;
            if (key_valid) seen = 1'b1;
        end
        chk(tag, 8'(seen), 8'd1);
    endtask

    task automatic wait_release(input string tag, input int budget);
        int n;
        n = 0;
        while (key_held && n < budget) begin tick(); n++; end
        chk(tag, 8'(key_held), 8'd0);
    endtask

    task automatic align(input int c, input int slot);
        int n;
        n = 0;
        while (!(m_mode == SCANNING && m_c == c && m_slot == slot) && n < 64) begin tick(); n++; end
        chk("align", 8'(n < 64), 8'd1);
    endtask

    initial begin
        int s0;
        int k0;
        model_reset();

        // Reset values while rst is held
        @(negedge clk);
        chk("rst_col", 8'(col), 8'h0E);
        chk("rst_code", 8'(key_code), 8'h00);
        chk("rst_valid", 8'(key_valid), 8'h00);
        chk("rst_held", 8'(key_held), 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Accept key C, then reset asynchronously while it is held
        keys[12] = 1'b1;
        wait_strobe("pre_rst_strobe", 100);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("async_col", 8'(col), 8'h0E);
        chk("async_code", 8'(key_code), 8'h00);
        chk("async_valid", 8'(key_valid), 8'h00);
        chk("async_held", 8'(key_held), 8'h00);
        keys = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Rotation after reset
        repeat (SD) tick();
        chk("rot1", 8'(col), 8'h0D);
        repeat (SD) tick();
        chk("rot2", 8'(col), 8'h0B);
        repeat (SD) tick();
        chk("rot3", 8'(col), 8'h07);
        repeat (SD) tick();
        chk("rot0", 8'(col), 8'h0E);

        // Press and release key C
        s0 = strobes;
        keys[12] = 1'b1;
        wait_strobe("c_strobe", 100);
        chk("c_code", 8'(key_code), 8'h0C);
        chk("c_held", 8'(key_held), 8'h01);
        chk("c_col", 8'(col), 8'h0E);
        repeat (40) tick();
        chk("c_col_frozen", 8'(col), 8'h0E);
`ifndef KEYPAD_AUTOREPEAT_EN
        chk("c_one_strobe", 8'(strobes - s0), 8'd1);
`endif
        keys = '0;
        wait_release("c_release", 60);
        chk("c_rel_col", 8'(col), 8'h0E);
        repeat (SD) tick();
        chk("c_resume", 8'(col), 8'h0D);

        // Single-sample glitch on row 1 / column 2 is rejected
        s0 = strobes;
        align(2, 1);
        keys[6] = 1'b1;
        repeat (3) tick();
        keys[6] = 1'b0;
        repeat (SD) tick();
        chk("glitch_col", 8'(col), 8'h07);
        chk("glitch_code", 8'(key_code), 8'h0C);
        chk("glitch_strobes", 8'(strobes - s0), 8'd0);

        // Rows 1 and 2 on column 2: lower row wins
        keys[6] = 1'b1;
        keys[10] = 1'b1;
        wait_strobe("multi_strobe", 200);
        chk("multi_code", 8'(key_code), 8'h06);
        keys = '0;
        wait_release("multi_release", 60);

        // Short release bounce while held is ignored
        keys[12] = 1'b1;
        wait_strobe("bounce_strobe", 200);
        repeat (8) tick();
        s0 = strobes;
        keys[12] = 1'b0;
        repeat (8) tick();
        keys[12] = 1'b1;
        repeat (12) tick();
        chk("bounce_held", 8'(key_held), 8'h01);
        chk("bounce_strobes", 8'(strobes - s0), 8'd0);
        keys = '0;
        wait_release("bounce_release", 60);

        // Long hold of key 5
        s0 = strobes;
        k0 = strobe_cyc.size();
        keys[5] = 1'b1;
        wait_strobe("hold5_strobe", 200);
        chk("hold5_code", 8'(key_code), 8'h05);
        repeat (60) tick();
`ifdef KEYPAD_AUTOREPEAT_EN
        chk("hold5_count", 8'(strobes - s0), 8'd4);
        if (strobe_cyc.size() >= k0 + 2)
            chk("hold5_interval", 8'(strobe_cyc[k0+1] - strobe_cyc[k0]), 8'd20);
`else
        chk("hold5_count", 8'(strobes - s0), 8'd1);
`endif
        keys = '0;
        wait_release("hold5_release", 60);

        // Random presses, releases and chords
        for (int it = 0; it < 40; it++) begin
            keys = 16'(1 << $urandom_range(15));
            if ($urandom_range(1) == 1) keys = keys | 16'(1 << $urandom_range(15));
            repeat ($urandom_range(4, 60)) tick();
            if ($urandom_range(3) == 0) begin
                keys = '0;
                repeat ($urandom_range(1, 9)) tick();
                keys = 16'(1 << $urandom_range(15));
                repeat ($urandom_range(4, 40)) tick();
            end
            keys = '0;
            repeat ($urandom_range(4, 50)) tick();
        end
        chk("total_strobes", 8'(strobes), 8'(m_strobes));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Scans a 4x4 active-low matrix keypad and produces the 4-bit key code consumed by the alarm controller's keypad input.
- Rotates a single low column drive and samples the synchronized row lines.
- Debounces both press and release.
- Reports each accepted press as a one-cycle `key_valid` strobe, with `key_code` held stable until the next accepted press.

## Interface
Parameters:
- `SCAN_DIV`, 1000: clocks per column slot; must be ≥ 4.
- `DEBOUNCE_CNT`, 8: consecutive matching samples required to accept a press or a release; must be ≥ 1.
- `REPEAT_CNT`, 50: samples between repeat strobes while a key is held; only used with the configuration macro.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `row`  in  4  keypad rows, active-low, externally pulled up, asynchronous to `clk`
- `col`  out  4  column drive; exactly one bit low at all times
- `key_code`  out  4  last accepted key, `{row_idx[1:0], col_idx[1:0]}`
- `key_valid`  out  1  one-cycle strobe on press acceptance
- `key_held`  out  1  high from acceptance until the release is accepted

## Operation
- **Row synchronization:** `row` passes through a 2-flop synchronizer. All decisions use the synchronized value `row_s`.
- **Slot counter:** runs 0..SCAN_DIV-1 and wraps. A "sample" is taken at slot count SCAN_DIV-1.
- **Row selection:** if more than one bit of `row_s` is low, the lowest row index wins.

State machine:
- **SCAN**
  - `col` drives column index `c` low.
  - At a sample with any row low: capture the candidate `{r,c}`, set the match count to 1, go to DEBOUNCE. If DEBOUNCE_CNT=1, go directly to PRESSED and strobe.
  - At a sample with no row low: `c` increments modulo 4.
- **DEBOUNCE**
  - Column is frozen.
  - At each sample, if the selected row equals the candidate row, increment the match count. On reaching DEBOUNCE_CNT, go to PRESSED.
  - Any mismatch (including no row low): go to SCAN with `c`+1.
- **PRESSED**
  - Column is frozen; `key_held`=1.
  - Release count increments on each sample where the candidate row is high. It clears on any sample where the candidate row is low.
  - When the release count reaches DEBOUNCE_CNT, go to SCAN with `c`=0.
  - Other rows going low in PRESSED are ignored.
- **On entry to PRESSED:**
  - `key_code` <= candidate.
  - `key_valid`=1 for exactly one cycle.
- `key_code` is not changed by rejected candidates or releases.
- `rst` at any time, including mid-debounce or PRESSED, returns to SCAN immediately.

## Timing
Reset values:
- `col`=4'b1110 (column 0)
- `key_code`=4'h0
- `key_valid`=0
- `key_held`=0
- state=SCAN
- slot, match and release counters = 0
- synchronizer flops = 4'hF

Timing rules:
- **Column change:** `col` changes on the clock edge after the sample that triggers it. The next sample falls SCAN_DIV clocks later, which covers the 2-cycle synchronizer plus settling.
- **Press latency:** the first low sample plus (DEBOUNCE_CNT-1)·SCAN_DIV clocks, then one registered cycle to `key_valid`/`key_code`/`key_held`. All three update on the same edge.
- **Release latency:** `key_held` falls on the edge after the DEBOUNCE_CNT-th consecutive high sample. `col` returns to column 0 on that same edge.
- **Slot counter:** never pauses across state changes.
- **Counter widths:** slot, match/release and repeat counters are sized with `$clog2` of their parameter. The match and release counters saturate at their limit.

## Configuration
- Macro: `KEYPAD_AUTOREPEAT_EN`.
- **Defined:**
  - In PRESSED, a repeat counter increments per sample.
  - On reaching REPEAT_CNT, `key_valid` pulses for one cycle with `key_code` unchanged, and the counter clears.
  - The counter also clears whenever the release count is non-zero.
- **Undefined:**
  - No repeat logic is compiled.
  - Exactly one `key_valid` per accepted press.
  - REPEAT_CNT is ignored.

## Test plan
Bench settings: SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_CNT=5 unless noted.

1. Assert `rst` mid-stream -> outputs immediately take the reset values: `col`=1110, `key_code`=0, `key_valid`=0, `key_held`=0. After release, `col` rotates 1110→1101→1011→0111 every 4 clocks.
2. Hold row 3 low whenever column 0 is driven -> exactly one `key_valid` pulse, `key_code`=4'hC, `key_held`=1, with `col` frozen at 1110. Release the key -> `key_held`=0 after 3 high samples, then rotation resumes from column 0.
3. Row 1 low for a single sample on column 2, then high -> no `key_valid`, `key_code` unchanged, and `col` advances to column 3 (0111).
4. Rows 1 and 2 both held low on column 2 -> `key_code`=4'h6.
5. Press and hold 4'hC; mid-PRESSED, bounce row 3 high for 2 samples, then back low -> `key_held` stays 1 and there is no new strobe.
6. With `KEYPAD_AUTOREPEAT_EN` defined, hold 4'h5 -> initial strobe, then a strobe every 5 samples (20 clocks). Without the macro, the same stimulus gives exactly one strobe.
